// File: rtl/dbg_trace_pkg.sv
// Shared types and register map for the multi-channel debug trace capture.
// Optional timestamp storage is enabled by DBG_TRACE_TIMESTAMP_EN.
package dbg_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_TVAL   = 3'd1;
  localparam logic [2:0] REG_TMASK  = 3'd2;
  localparam logic [2:0] REG_TCH    = 3'd3;
  localparam logic [2:0] REG_POST   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_PTRS   = 3'd6;
  localparam logic [2:0] REG_TS     = 3'd7;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/dbg_trace_ram.sv
// Simple dual-port synchronous RAM: one write, one registered read.
// A same-address read and write in one cycle returns the old contents.
module dbg_trace_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_trace_capture.sv
// Triggered circular-buffer trace capture for NUM_CH sample buses.
// Define DBG_TRACE_TIMESTAMP_EN to store a free-running timestamp per entry.
module dbg_trace_capture
  import dbg_trace_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SMP_W  = 64,
  parameter int DEPTH  = 512,
  parameter int TS_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       smp_valid_i,
  input  logic [NUM_CH*SMP_W-1:0]    smp_i,
  input  logic                       reg_en_i,
  input  logic                       reg_we_i,
  input  logic [2:0]                 reg_addr_i,
  input  logic [63:0]                reg_wdata_i,
  output logic [63:0]                reg_rdata_o,
  input  logic [$clog2(DEPTH)-1:0]   buf_addr_i,
  output logic [NUM_CH*SMP_W-1:0]    buf_rdata_o,
  output logic [TS_W-1:0]            buf_ts_o,
  output logic                       irq_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW  = NUM_CH * SMP_W;
`ifdef DBG_TRACE_TIMESTAMP_EN
  localparam int RW  = DW + TS_W;
`else
  localparam int RW  = DW;
`endif
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [63:0]     tval_q, tval_d;
  logic [63:0]     tmask_q, tmask_d;
  logic [CHW-1:0]  tch_q, tch_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   tidx_q, tidx_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;
  logic            irq_q, irq_d;
  logic [63:0]     rdata_q, rdata_d;

  logic            wr_en, rd_en, arm, abort;
  logic            store, hit;
  logic [SMP_W-1:0] ch_smp;
  logic [AW-1:0]   post_wr;
  logic [63:0]     rd_val;
  logic [RW-1:0]   ram_wdata, ram_rdata;

`ifdef DBG_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] tts_q, tts_d;

  always_comb begin
    ts_d  = ts_q + TS_W'(1);
    tts_d = tts_q;
    if (store && state_q == ST_ARMED && hit) tts_d = ts_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q  <= '0;
      tts_q <= '0;
    end else begin
      ts_q  <= ts_d;
      tts_q <= tts_d;
    end
  end

  assign ram_wdata = {ts_q, smp_i};
  assign buf_ts_o  = ram_rdata[DW +: TS_W];
`else
  assign ram_wdata = smp_i;
  assign buf_ts_o  = '0;
`endif

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    ch_smp = smp_i[SMP_W-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (int'(tch_q) == k) ch_smp = smp_i[k*SMP_W +: SMP_W];
    end
  end

  assign hit = ((ch_smp ^ tval_q[SMP_W-1:0]) & tmask_q[SMP_W-1:0]) == '0;

  assign wr_en = reg_en_i & reg_we_i;
  assign rd_en = reg_en_i & ~reg_we_i;
  assign arm   = wr_en && reg_addr_i == REG_CTRL && reg_wdata_i[CTRL_ARM];
  assign abort = wr_en && reg_addr_i == REG_CTRL && reg_wdata_i[CTRL_ABORT];
  assign store = smp_valid_i && (state_q == ST_ARMED || state_q == ST_POST);
  assign post_wr = (|reg_wdata_i[63:AW]) ? LAST : reg_wdata_i[AW-1:0];

  always_comb begin
    tval_d  = tval_q;
    tmask_d = tmask_q;
    tch_d   = tch_q;
    post_d  = post_q;
    if (wr_en) begin
      unique case (1'b1)
        reg_addr_i == REG_TVAL:  tval_d  = reg_wdata_i;
        reg_addr_i == REG_TMASK: tmask_d = reg_wdata_i;
        reg_addr_i == REG_TCH:   tch_d   = reg_wdata_i[CHW-1:0];
        reg_addr_i == REG_POST:  post_d  = post_wr;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    tidx_d  = tidx_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    done_d  = done_q;
    if (store) begin
      wptr_d = wptr_q + AW'(1);
      if (wptr_q == LAST) wrap_d = 1'b1;
    end
    case (state_q)
      ST_ARMED: begin
        if (store && hit) begin
          tidx_d = wptr_q;
          rem_d  = post_q;
          if (post_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (store) begin
          rem_d = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Abort takes priority over a simultaneous arm.
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
      wptr_d  = '0;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
    end
    irq_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr_i)
      REG_TVAL:   rd_val = tval_q;
      REG_TMASK:  rd_val = tmask_q;
      REG_TCH:    rd_val[CHW-1:0] = tch_q;
      REG_POST:   rd_val[AW-1:0] = post_q;
      REG_STATUS: rd_val[3:0] = {wrap_q, done_q, state_q};
      REG_PTRS: begin
        rd_val[32 +: AW] = tidx_q;
        rd_val[AW-1:0]   = wptr_q;
      end
`ifdef DBG_TRACE_TIMESTAMP_EN
      REG_TS:     rd_val[TS_W-1:0] = tts_q;
`endif
      default:    rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tval_q  <= '0;
      tmask_q <= '0;
      tch_q   <= '0;
      post_q  <= '0;
      wptr_q  <= '0;
      tidx_q  <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tval_q  <= tval_d;
      tmask_q <= tmask_d;
      tch_q   <= tch_d;
      post_q  <= post_d;
      wptr_q  <= wptr_d;
      tidx_q  <= tidx_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  dbg_trace_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (store),
    .waddr_i (wptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (buf_addr_i),
    .rdata_o (ram_rdata)
  );

  assign buf_rdata_o = ram_rdata[DW-1:0];
  assign reg_rdata_o = rdata_q;
  assign irq_o       = irq_q;

endmodule
